pipe_issue: RTL and testbench

// Instruction issue stage that feeds the 4-stage register/ALU/memory pipeline (rs1,rs2,rd,func,addr).
// - Buffers 28-bit instruction words in a small FIFO and decodes them into operand fields.
// - Detects RAW hazards against destinations still in flight and inserts bubbles until they clear.
// - Issues at most one instruction per cycle; the pipeline consumes fields only when iss_valid=1.

---
 rtl/pipe_issue_if.sv | 29 ++
 rtl/pipe_issue.sv | 128 ++++++++++++
 tb/tb_pipe_issue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_issue_if.sv
// Handshake and issue bundle between the instruction source,
// the issue stage and the register/ALU/memory pipeline.
interface pipe_issue_if;
   logic        in_valid;
   logic [27:0] in_instr;
   logic        in_ready;
   logic        stall_in;
   logic        iss_valid;
   logic [3:0]  rs1;
   logic [3:0]  rs2;
   logic [3:0]  rd;
   logic [3:0]  func;
   logic [7:0]  addr;
   logic [2:0]  fifo_count;
   logic [7:0]  illegal_cnt;
   logic [15:0] issued_cnt;

   modport master (
      output in_valid, in_instr, stall_in,
      input  in_ready, iss_valid, rs1, rs2, rd, func, addr,
      input  fifo_count, illegal_cnt, issued_cnt
   );

   modport slave (
      input  in_valid, in_instr, stall_in,
      output in_ready, iss_valid, rs1, rs2, rd, func, addr,
      output fifo_count, illegal_cnt, issued_cnt
   );
endinterface

// File: rtl/pipe_issue.sv
// Issue stage: instruction FIFO, RAW scoreboard against in-flight
// destinations, and registered decoded fields for the pipeline.
module pipe_issue #(
   parameter int DEPTH     = 4,
   parameter int HAZ_DEPTH = 2,
   parameter int FUNC_MAX  = 11
) (
   input logic         clk,
   input logic         rst_n,
   pipe_issue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [3:0] func;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [3:0] rd;
      logic [7:0] addr;
   } dec_t;

   typedef struct packed {
      logic       v;
      logic [3:0] rd;
   } sb_t;

   dec_t          mem_q [DEPTH];
   dec_t          mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   sb_t           sb_q [HAZ_DEPTH];
   sb_t           sb_d [HAZ_DEPTH];
   logic          iss_q, iss_d;
   dec_t          fld_q, fld_d;
   logic [7:0]    ill_q, ill_d;
   logic [15:0]   icnt_q, icnt_d;

   dec_t head;
   logic full, empty, push, pop, hazard, legal;

   assign head  = mem_q[rd_ptr_q];
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign push  = bus.in_valid && !full;
   assign legal = (head.func <= 4'(FUNC_MAX));

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         if (sb_q[i].v && (sb_q[i].rd == head.rs1 ||
                           sb_q[i].rd == head.rs2))
            hazard = 1'b1;
      end
   end

   assign pop = !empty && !bus.stall_in && !hazard;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      iss_d    = 1'b0;
      fld_d    = fld_q;
      ill_d    = ill_q;
      icnt_d   = icnt_q;
      sb_d     = sb_q;
      if (push) begin
         mem_d[wr_ptr_q] = {bus.in_instr[27:12], bus.in_instr[7:0]};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         if (legal) begin
            iss_d  = 1'b1;
            fld_d  = head;
            icnt_d = icnt_q + 16'd1;
         end else if (ill_q != 8'hff) begin
            ill_d = ill_q + 8'd1;
         end
      end
      // a stalled pipeline keeps every in-flight destination in place
      if (!bus.stall_in) begin
         for (int i = HAZ_DEPTH - 1; i > 0; i--)
            sb_d[i] = sb_q[i-1];
         sb_d[0] = '{v: pop && legal, rd: head.rd};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         for (int i = 0; i < HAZ_DEPTH; i++)
            sb_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         iss_q    <= 1'b0;
         fld_q    <= '0;
         ill_q    <= '0;
         icnt_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         sb_q     <= sb_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         iss_q    <= iss_d;
         fld_q    <= fld_d;
         ill_q    <= ill_d;
         icnt_q   <= icnt_d;
      end
   end

   assign bus.in_ready    = !full;
   assign bus.iss_valid   = iss_q;
   assign bus.func        = fld_q.func;
   assign bus.rs1         = fld_q.rs1;
   assign bus.rs2         = fld_q.rs2;
   assign bus.rd          = fld_q.rd;
   assign bus.addr        = fld_q.addr;
   assign bus.fifo_count  = 3'(cnt_q);
   assign bus.illegal_cnt = ill_q;
   assign bus.issued_cnt  = icnt_q;
endmodule

// File: tb/tb_pipe_issue.sv
// Self-checking bench for pipe_issue: queue-based reference model,
// directed scenarios and a randomized stream across pointer wrap.
module tb_pipe_issue;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_issue_if bus ();
   pipe_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model
   logic [27:0] q[$];
   int          infl[$];
   logic [23:0] m_fld;
   logic        m_iss;
   int          m_ill;
   int          m_icnt;
   int          cyc;
   int          iss_cyc[$];

   function automatic void model_reset();
      q.delete();
      infl = '{-1, -1};
      m_fld = '0;
      m_iss = 1'b0;
      m_ill = 0;
      m_icnt = 0;
   endfunction

   function automatic bit model_step(bit v, logic [27:0] w, bit st);
      bit rdy;
      bit hz;
      int nrd;
      logic [27:0] h;
      rdy = (q.size() < 4);
      hz = 1'b0;
      nrd = -1;
      m_iss = 1'b0;
      if (q.size() > 0)
         foreach (infl[i])
            if (infl[i] >= 0 && (infl[i] == int'(q[0][23:20]) ||
                                 infl[i] == int'(q[0][19:16])))
               hz = 1'b1;
      if (q.size() > 0 && !st && !hz) begin
         h = q.pop_front();
         if (h[27:24] <= 4'd11) begin
            m_iss = 1'b1;
            m_fld = {h[27:12], h[7:0]};
            m_icnt = (m_icnt + 1) % 65536;
            nrd = int'(h[15:12]);
         end else if (m_ill < 255) begin
            m_ill++;
         end
      end
      if (!st) begin
         infl.push_front(nrd);
         void'(infl.pop_back());
      end
      if (v && rdy) q.push_back(w);
      return v && rdy;
   endfunction

   function automatic logic [27:0] mk(int f, int a, int b, int d, int ad);
      return {f[3:0], a[3:0], b[3:0], d[3:0], 4'h0, ad[7:0]};
   endfunction

   task automatic compare_all();
      check("iss_valid", 32'(bus.iss_valid), 32'(m_iss));
      check("fields", 32'({bus.func, bus.rs1, bus.rs2, bus.rd, bus.addr}),
            32'(m_fld));
      check("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
      check("in_ready", 32'(bus.in_ready), 32'(q.size() < 4));
      check("illegal_cnt", 32'(bus.illegal_cnt), 32'(m_ill));
      check("issued_cnt", 32'(bus.issued_cnt), 32'(m_icnt));
   endtask

   task automatic cycle(bit v, logic [27:0] w, bit st, output bit acc);
      bus.in_valid = v;
      bus.in_instr = w;
      bus.stall_in = st;
      @(posedge clk);
      acc = model_step(v, w, st);
      cyc++;
      #1;
      compare_all();
      if (bus.iss_valid) iss_cyc.push_back(cyc);
   endtask

   task automatic send(logic [27:0] w, bit st);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         cycle(1'b1, w, st, acc);
         n++;
      end
      check("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic idle(int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 28'h0, 1'b0, acc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 60) begin
         idle(1);
         n++;
      end
      idle(3);
      check("drain_count", 32'(bus.fifo_count), 32'd0);
   endtask

   task automatic reset_checks(string pfx);
      check({pfx, "_iss"}, 32'(bus.iss_valid), 32'd0);
      check({pfx, "_cnt"}, 32'(bus.fifo_count), 32'd0);
      check({pfx, "_rdy"}, 32'(bus.in_ready), 32'd1);
      check({pfx, "_ill"}, 32'(bus.illegal_cnt), 32'd0);
      check({pfx, "_issued"}, 32'(bus.issued_cnt), 32'd0);
   endtask

   initial begin
      bit acc;
      int pushed;
      int budget;
      logic [27:0] w;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.stall_in = 1'b0;
      cyc = 0;
      model_reset();
      #2;
      reset_checks("rst");
      check("rst_fields",
            32'({bus.func, bus.rs1, bus.rs2, bus.rd, bus.addr}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // T2 back-to-back stream
      iss_cyc.delete();
      send(mk(0, 3, 5, 10, 8'h11), 1'b0);
      send(mk(2, 3, 8, 12, 8'h22), 1'b0);
      send(mk(1, 7, 3, 13, 8'h33), 1'b0);
      drain();
      check("t2_issues", 32'(iss_cyc.size()), 32'd3);
      if (iss_cyc.size() == 3) begin
         check("t2_gap1", 32'(iss_cyc[1] - iss_cyc[0]), 32'd1);
         check("t2_gap2", 32'(iss_cyc[2] - iss_cyc[1]), 32'd1);
      end
      check("t2_issued_cnt", 32'(bus.issued_cnt), 32'd3);

      // T3 RAW hazard
      iss_cyc.delete();
      send(mk(0, 3, 5, 10, 8'h5a), 1'b0);
      send(mk(1, 10, 5, 14, 8'ha5), 1'b0);
      drain();
      check("t3_issues", 32'(iss_cyc.size()), 32'd2);
      if (iss_cyc.size() == 2)
         check("t3_gap", 32'(iss_cyc[1] - iss_cyc[0]), 32'd3);
      check("t3_addr", 32'(bus.addr), 32'ha5);
      check("t3_rd", 32'(bus.rd), 32'd14);

      // T4 full FIFO under stall
      iss_cyc.delete();
      for (int i = 0; i < 4; i++)
         send(mk(i, i + 1, i + 1, 9 + i, 8'h40 + i), 1'b1);
      check("t4_ready_low", 32'(bus.in_ready), 32'd0);
      check("t4_count", 32'(bus.fifo_count), 32'd4);
      w = mk(5, 1, 2, 15, 8'h44);
      cycle(1'b1, w, 1'b1, acc);
      cycle(1'b1, w, 1'b1, acc);
      check("t4_held_count", 32'(bus.fifo_count), 32'd4);
      send(w, 1'b0);
      drain();
      check("t4_issues", 32'(iss_cyc.size()), 32'd5);
      check("t4_last_addr", 32'(bus.addr), 32'h44);

      // T5 illegal word dropped without extra bubble
      iss_cyc.delete();
      send(mk(3, 1, 2, 4, 8'h61), 1'b0);
      send(mk(12, 5, 6, 7, 8'h62), 1'b0);
      send(mk(4, 8, 9, 11, 8'h63), 1'b0);
      drain();
      check("t5_issues", 32'(iss_cyc.size()), 32'd2);
      if (iss_cyc.size() == 2)
         check("t5_gap", 32'(iss_cyc[1] - iss_cyc[0]), 32'd2);
      check("t5_illegal", 32'(bus.illegal_cnt), 32'd1);

      // T1 async reset mid-stream
      send(mk(0, 1, 1, 2, 8'h71), 1'b0);
      send(mk(0, 3, 3, 4, 8'h72), 1'b0);
      check("t1_pre_iss", 32'(bus.iss_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      reset_checks("t1");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // T6 random stream across pointer wrap
      iss_cyc.delete();
      pushed = 0;
      budget = 0;
      w = '0;
      while (pushed < 300 && budget < 5000) begin
         if (!acc || budget == 0)
            ;
         w = {4'($urandom_range(0, 11)), 4'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom), 8'($urandom)};
         acc = 1'b0;
         while (!acc && budget < 5000) begin
            cycle(($urandom % 4) != 0, w, ($urandom % 4) == 0, acc);
            budget++;
         end
         if (acc) pushed++;
      end
      check("t6_pushed", 32'(pushed), 32'd300);
      drain();
      check("t6_issues", 32'(iss_cyc.size()), 32'd300);
      check("t6_issued_cnt", 32'(bus.issued_cnt), 32'd300);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
